// File: rtl/hdmi_video_timing.sv
// rtl/hdmi_video_timing.sv - raster timing generator for the HDMI text-mode pipeline
//
// Purpose:
//   Free-running horizontal/vertical raster counters over a parameterised
//   video mode. The counter origin (0,0) is the first active pixel. Each
//   line and each frame is laid out as active, front porch, sync, back porch.
//   All outputs are registered decodes of the counter state, so every output
//   describes the counter value of the previous cycle (latency 1).
//
// Ports:
//   clk            in   pixel clock
//   reset          in   synchronous, active-high reset (h = v = 0, outputs idle)
//   out_active     out  pixel lies inside the active area
//   out_h_sync     out  horizontal sync, asserted level H_SYNC_POL
//   out_v_sync     out  vertical sync, asserted level V_SYNC_POL
//   out_h_start    out  first active pixel of an active line
//   out_v_start    out  every active pixel of the first active line
//   out_frame_end  out  one-cycle pulse on the first pixel after the last
//                       active pixel of a frame (safe point for scroll updates)

module hdmi_video_timing #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    output logic out_active,
    output logic out_h_sync,
    output logic out_v_sync,
    output logic out_h_start,
    output logic out_v_start,
    output logic out_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Guard the degenerate single-count case so the counters never collapse
    // to zero width.
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    // Region boundaries. Every boundary is strictly below the total, so all
    // of them fit in the counter width.
    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEGIN = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_BEGIN = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [HW-1:0] h;
    logic [VW-1:0] v;

    logic h_in_active;
    logic v_in_active;
    logic h_in_sync;
    logic v_in_sync;
    logic h_is_zero;
    logic v_is_zero;
    logic h_at_act_end;
    logic v_at_act_last;

    // Raster counters. Reset drops straight to the origin; a line in
    // progress is abandoned rather than completed.
    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
                v <= '0;
            end else begin
                v <= v + 1'b1;
            end
        end else begin
            h <= h + 1'b1;
        end
    end

    // Region decode of the current counter state.
    always_comb begin
        h_in_active   = (h < H_ACT_END);
        v_in_active   = (v < V_ACT_END);
        h_in_sync     = (h >= H_SYNC_BEGIN) && (h < H_SYNC_END);
        v_in_sync     = (v >= V_SYNC_BEGIN) && (v < V_SYNC_END);
        h_is_zero     = (h == '0);
        v_is_zero     = (v == '0);
        h_at_act_end  = (h == H_ACT_END);
        v_at_act_last = (v == V_ACT_LAST);
    end

    // Registered outputs. v only moves when h wraps, so out_v_sync can only
    // change on line boundaries; out_h_sync keeps toggling through vertical
    // blanking because it ignores v.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_active    <= 1'b0;
            out_h_start   <= 1'b0;
            out_v_start   <= 1'b0;
            out_frame_end <= 1'b0;
            out_h_sync    <= !H_SYNC_POL;
            out_v_sync    <= !V_SYNC_POL;
        end else begin
            out_active    <= h_in_active && v_in_active;
            out_h_start   <= h_is_zero && v_in_active;
            out_v_start   <= v_is_zero && h_in_active;
            out_frame_end <= h_at_act_end && v_at_act_last;
            out_h_sync    <= h_in_sync ? H_SYNC_POL : !H_SYNC_POL;
            out_v_sync    <= v_in_sync ? V_SYNC_POL : !V_SYNC_POL;
        end
    end

    // A zero-width region would break the raster layout and the counter
    // ranges; flag it as a configuration error in simulation.
    always_ff @(posedge clk) begin
        assert (H_ACTIVE >= 1 && H_FRONT >= 1 && H_SYNC >= 1 && H_BACK >= 1 &&
                V_ACTIVE >= 1 && V_FRONT >= 1 && V_SYNC >= 1 && V_BACK >= 1)
        else $error("hdmi_video_timing: every timing parameter must be >= 1");
    end

endmodule
